// File: rtl/bmp_upload_ctrl.sv
// BMP download sequencer: validates the header, buffers pixel bytes and writes them to SDRAM port1 over a toggle req/ack handshake.
// Optional macro BMP_VFLIP_EN stores rows top-down by remapping each pixel byte's destination address.
module bmp_upload_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_W      = 12
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-2:0] port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              bmp_loaded,
  output logic              bmp_error,
  output logic [DIM_W-1:0]  bmp_width,
  output logic [DIM_W-1:0]  bmp_height,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXELS, S_DRAIN, S_DONE, S_ERROR} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  state_t             state_q, state_d;
  logic               dl_q, ack_q, req_q, we_q, loaded_q, error_q, busy_q, pend_q;
  logic [ADDR_W-2:0]  a_q;
  logic [1:0]         ds_q;
  logic [15:0]        d_q;
  logic [23:0]        offset_q;
  logic [DIM_W-1:0]   width_q, height_q;
  logic [24:0]        last_addr_q;
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;

  logic               dl_rise, dl_fall, ack_evt, fifo_empty, fifo_full;
  logic               push, pop, issue, flush, hdr_bad, at_offset, in_range, keep;
  logic [24:0]        rel_full;
  logic [ADDR_W-1:0]  rel, dest;
  logic [2*DIM_W-1:0] area;
  logic [2*DIM_W+1:0] limit;
  entry_t             head;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign ack_evt    = port_ack != ack_q;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == (PTR_W+1)'(FIFO_DEPTH);
  assign head       = mem[rd_ptr_q];
  assign rel_full   = ioctl_addr - {1'b0, offset_q};
  assign rel        = rel_full[ADDR_W-1:0];
  assign area       = {{DIM_W{1'b0}}, width_q} * {{DIM_W{1'b0}}, height_q};
  assign limit      = {area, 2'b00};
  assign at_offset  = (ioctl_addr >= 25'd30) && (ioctl_addr == {1'b0, offset_q});
  assign in_range   = keep && (32'(rel) < 32'(limit));

`ifdef BMP_VFLIP_EN
  logic [DIM_W+1:0]   stride_q, col_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic               flip_end_q;
  logic [2*DIM_W+1:0] rb_full;

  assign rb_full = {{(DIM_W+2){1'b0}}, height_q - 1'b1} * {{DIM_W{1'b0}}, width_q, 2'b00};
  assign dest    = row_base_q + ADDR_W'(col_q);
  assign keep    = ~flip_end_q;

  // Geometry is re-registered every HEADER cycle so row_base is settled long before the first pixel byte.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stride_q   <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      flip_end_q <= 1'b0;
    end else if (push) begin
      if (col_q == stride_q - 1'b1) begin
        col_q <= '0;
        if (row_base_q == '0) flip_end_q <= 1'b1;
        else                  row_base_q <= row_base_q - ADDR_W'(stride_q);
      end else begin
        col_q <= col_q + 1'b1;
      end
    end else if (state_q == S_HEADER) begin
      stride_q   <= {width_q, 2'b00};
      row_base_q <= ADDR_W'(rb_full);
      col_q      <= '0;
      flip_end_q <= 1'b0;
    end
  end
`else
  assign dest = rel;
  assign keep = 1'b1;
`endif

  always_comb begin
    hdr_bad = 1'b0;
    case (ioctl_addr)
      25'd0:   hdr_bad = ioctl_dout != 8'h42;
      25'd1:   hdr_bad = ioctl_dout != 8'h4D;
      25'd13:  hdr_bad = (ioctl_dout != 8'h00) || (offset_q < 24'd30);
      25'd28:  hdr_bad = ioctl_dout != 8'd32;
      default: hdr_bad = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (dl_rise) begin
      state_d = S_HEADER;
      flush   = 1'b1;
    end else begin
      case (state_q)
        S_HEADER:
          if (dl_fall)              state_d = S_ERROR;
          else if (ioctl_wr) begin
            if (hdr_bad)            state_d = S_ERROR;
            else if (at_offset) begin
              state_d = S_PIXELS;
              push    = in_range;
            end
          end
        S_PIXELS:
          if (dl_fall)              state_d = S_DRAIN;
          else if (ioctl_wr) begin
            if (ioctl_addr != last_addr_q + 25'd1) state_d = S_ERROR;
            else                                   push    = in_range;
          end
        S_DRAIN:
          if (fifo_empty && (req_q == port_ack)) state_d = S_DONE;
        default: ;
      endcase
    end
    if (push && fifo_full) begin
      push    = 1'b0;
      state_d = S_ERROR;
    end
    if (state_d == S_ERROR) flush = 1'b1;
  end

  // A request is only retired by the ack edge it caused; a flush forgets it so a late ack pops nothing.
  assign pop   = pend_q && ack_evt && (port_ack == req_q);
  assign issue = (state_q != S_ERROR) && !flush && !fifo_empty && !pend_q &&
                 (req_q == port_ack) && !ack_evt;

  // NOTE: the FIFO storage has no reset; count/pointers define validity, so only control state is cleared.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr_q] <= '{addr: dest, data: ioctl_dout};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      ack_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      a_q         <= '0;
      ds_q        <= '0;
      d_q         <= '0;
      offset_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      last_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      ack_q   <= port_ack;
      busy_q  <= (state_d == S_HEADER) || (state_d == S_PIXELS) || (state_d == S_DRAIN);
      if (ioctl_wr) last_addr_q <= ioctl_addr;

      if (dl_rise) begin
        loaded_q <= 1'b0;
        error_q  <= 1'b0;
        offset_q <= '0;
      end else if (state_d == S_ERROR) begin
        error_q <= 1'b1;
      end
      if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
        loaded_q <= 1'b1;
        we_q     <= 1'b0;
      end

      if ((state_q == S_HEADER) && ioctl_wr && !dl_fall) begin
        case (ioctl_addr)
          25'd10:  offset_q[7:0]        <= ioctl_dout;
          25'd11:  offset_q[15:8]       <= ioctl_dout;
          25'd12:  offset_q[23:16]      <= ioctl_dout;
          25'd18:  width_q[7:0]         <= ioctl_dout;
          25'd19:  width_q[DIM_W-1:8]   <= ioctl_dout[DIM_W-9:0];
          25'd22:  height_q[7:0]        <= ioctl_dout;
          25'd23:  height_q[DIM_W-1:8]  <= ioctl_dout[DIM_W-9:0];
          default: ;
        endcase
      end

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end

      if (flush)      pend_q <= 1'b0;
      else if (issue) pend_q <= 1'b1;
      else if (pop)   pend_q <= 1'b0;

      if (issue) begin
        req_q <= ~req_q;
        we_q  <= 1'b1;
        a_q   <= head.addr[ADDR_W-1:1];
        ds_q  <= {head.addr[0], ~head.addr[0]};
        d_q   <= {head.data, head.data};
      end
    end
  end

  assign port_req   = req_q;
  assign port_a     = a_q;
  assign port_ds    = ds_q;
  assign port_d     = d_q;
  assign port_we    = we_q;
  assign bmp_loaded = loaded_q;
  assign bmp_error  = error_q;
  assign bmp_width  = width_q;
  assign bmp_height = height_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_bmp_upload_ctrl.sv
// Scoreboard bench for bmp_upload_ctrl: stimulus pushes expected SDRAM writes, a monitor pops them on each port_req toggle.
module tb_bmp_upload_ctrl;
  localparam int ADDR_W     = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int DIM_W      = 12;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download, ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              port_req, port_ack;
  logic [ADDR_W-2:0] port_a;
  logic [1:0]        port_ds;
  logic [15:0]       port_d;
  logic              port_we;
  logic              bmp_loaded, bmp_error, busy;
  logic [DIM_W-1:0]  bmp_width, bmp_height;

  bmp_upload_ctrl #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .DIM_W(DIM_W)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .port_we(port_we),
    .bmp_loaded(bmp_loaded), .bmp_error(bmp_error),
    .bmp_width(bmp_width), .bmp_height(bmp_height), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [ADDR_W-2:0] a;
    logic [1:0]        ds;
    logic [15:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0, failures = 0, writes_seen = 0;
  int         ack_delay = 3;
  bit         ack_hold = 1'b0;
  int         img_w = 4, img_h = 2, img_off = 54;
  logic [7:0] magic0 = 8'h42;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] file_byte(int a);
    case (a)
      0:  return magic0;
      1:  return 8'h4D;
      10: return img_off[7:0];
      11: return img_off[15:8];
      12: return img_off[23:16];
      18: return img_w[7:0];
      19: return img_w[15:8];
      22: return img_h[7:0];
      23: return img_h[15:8];
      28: return 8'd32;
      default: return (a >= img_off) ? 8'(a * 7 + 3) : 8'h00;
    endcase
  endfunction

  // Reference placement: bottom-up file order, or top-down rows when flipping.
  function automatic wr_t exp_write(int rel, logic [7:0] b);
    int  dest;
    int  stride;
    wr_t w;
    stride = img_w * 4;
`ifdef BMP_VFLIP_EN
    dest = (img_h - 1 - rel / stride) * stride + rel % stride;
`else
    dest = rel;
`endif
    w.a  = dest[ADDR_W-1:1];
    w.ds = {dest[0], ~dest[0]};
    w.d  = {b, b};
    return w;
  endfunction

  task automatic strobe(int a, logic [7:0] b, int gap);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = b;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic send_range(int first, int last, int gap, int max_exp);
    int         n_exp;
    logic [7:0] b;
    n_exp = 0;
    for (int a = first; a <= last; a++) begin
      b = file_byte(a);
      if (a >= img_off && (a - img_off) < img_w * img_h * 4 && n_exp < max_exp) begin
        exp_q.push_back(exp_write(a - img_off, b));
        n_exp++;
      end
      strobe(a, b, gap);
    end
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic wait_loaded(int budget);
    int n;
    n = 0;
    while (bmp_loaded !== 1'b1 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check("loaded_wait", bmp_loaded, 1);
  endtask

  // SDRAM port1 model: answers each request toggle ack_delay cycles later, unless held.
  initial begin
    port_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset && port_req !== port_ack) begin
        repeat (ack_delay - 1) @(negedge clk_sys);
        while (ack_hold) @(negedge clk_sys);
        port_ack = port_req;
      end
    end
  end

  // Monitor: every new request must match the oldest outstanding expectation.
  initial begin
    logic prev;
    wr_t  e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev = port_req;
      end else if (port_req !== prev) begin
        prev = port_req;
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got a=0x%0h ds=%b, expected no request", port_a, port_ds);
        end else begin
          e = exp_q.pop_front();
          check("write_a", port_a, e.a);
          check("write_ds", port_ds, e.ds);
          check("write_d", port_d, e.d);
          check("write_we", port_we, 1);
        end
      end
    end
  end

  initial begin
    int ws0;
    int n;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_req", port_req, 0);
    check("rst_we", port_we, 0);
    check("rst_a", port_a, 0);
    check("rst_ds", port_ds, 0);
    check("rst_d", port_d, 0);
    check("rst_loaded", bmp_loaded, 0);
    check("rst_error", bmp_error, 0);
    check("rst_width", bmp_width, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Valid 4x2 image, 32 writes
    ws0 = writes_seen;
    start_dl();
    send_range(0, 53, 0, 1000);
    check("hdr_width", bmp_width, 4);
    check("hdr_height", bmp_height, 2);
    check("hdr_busy", busy, 1);
    send_range(54, 85, 8, 1000);
    end_dl();
    wait_loaded(200);
    check("ok_error", bmp_error, 0);
    check("ok_we_low", port_we, 0);
    check("ok_busy", busy, 0);
    check("ok_writes", writes_seen - ws0, 32);
    check("ok_queue", exp_q.size(), 0);

    // Bad magic
    ws0 = writes_seen;
    magic0 = 8'h41;
    start_dl();
    check("badmagic_cleared", bmp_loaded, 0);
    strobe(0, file_byte(0), 0);
    check("badmagic_error", bmp_error, 1);
    check("badmagic_busy", busy, 0);
    send_range(1, 70, 0, 0);
    end_dl();
    repeat (10) @(negedge clk_sys);
    check("badmagic_writes", writes_seen - ws0, 0);
    check("badmagic_loaded", bmp_loaded, 0);
    check("badmagic_sticky", bmp_error, 1);
    magic0 = 8'h42;

    // Overflow with ack withheld
    ws0 = writes_seen;
    ack_hold = 1'b1;
    start_dl();
    check("ovf_error_cleared", bmp_error, 0);
    send_range(0, 53, 0, 0);
    send_range(54, 65, 0, 1);
    check("ovf_error", bmp_error, 1);
    check("ovf_pending", port_req != port_ack, 1);
    repeat (16) @(negedge clk_sys);
    ack_hold = 1'b0;
    n = 0;
    while (port_req !== port_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    check("ovf_ack_done", port_req == port_ack, 1);
    repeat (10) @(negedge clk_sys);
    check("ovf_writes", writes_seen - ws0, 1);
    check("ovf_queue", exp_q.size(), 0);
    check("ovf_loaded", bmp_loaded, 0);
    end_dl();
    repeat (3) @(negedge clk_sys);

    // Download ends early after 10 pixel bytes
    ws0 = writes_seen;
    start_dl();
    send_range(0, 53, 0, 0);
    send_range(54, 63, 8, 1000);
    end_dl();
    wait_loaded(200);
    check("short_error", bmp_error, 0);
    check("short_writes", writes_seen - ws0, 10);
    check("short_queue", exp_q.size(), 0);

    // Reset with a request outstanding, then a clean restart
    ack_hold = 1'b1;
    start_dl();
    send_range(0, 53, 0, 0);
    send_range(54, 56, 0, 1);
    n = 0;
    while (port_req === port_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    check("mid_outstanding", port_req != port_ack, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check("mid_rst_req", port_req, 0);
    check("mid_rst_we", port_we, 0);
    check("mid_rst_a", port_a, 0);
    check("mid_rst_ds", port_ds, 0);
    check("mid_rst_d", port_d, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_width", bmp_width, 0);
    exp_q.delete();
    @(negedge clk_sys);
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (4) @(negedge clk_sys);
    ws0 = writes_seen;
    start_dl();
    send_range(0, 85, 8, 1000);
    end_dl();
    wait_loaded(200);
    check("restart_error", bmp_error, 0);
    check("restart_writes", writes_seen - ws0, 32);
    check("restart_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck handshake still ends the run with a summary.
  initial begin
    #400000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
